// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER pipeline hazard controller.
package otter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FWD_SEL_W  = 2;
  localparam int unsigned FLUSH_CNT_W = 2;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hz_state_t;

  // Destination write port of a downstream pipeline stage.
  typedef struct packed {
    reg_addr_t rd;
    logic      reg_write;
  } wr_port_t;

  // True when a live write port targets a non-x0 source address.
  function automatic logic wr_hits(input wr_port_t wp, input reg_addr_t rs);
    return wp.reg_write && (rs != '0) && (wp.rd == rs);
  endfunction

endpackage

// File: rtl/otter_hazard_ctrl_if.sv
// Pipeline-register taps into the hazard controller and its control outputs.
interface otter_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import otter_pkg::*;

  reg_addr_t        de_rs1_addr;
  reg_addr_t        de_rs2_addr;
  logic             de_rs1_used;
  logic             de_rs2_used;
  reg_addr_t        ex_rd_addr;
  logic             ex_reg_write;
  logic             ex_is_load;
  logic             ex_ctrl_taken;
  reg_addr_t        mem_rd_addr;
  logic             mem_reg_write;
  reg_addr_t        wb_rd_addr;
  logic             wb_reg_write;

  logic             stall_if;
  logic             stall_de;
  logic             flush_de;
  logic             flush_ex;
  fwd_sel_t         fwd_a_sel;
  fwd_sel_t         fwd_b_sel;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
    output ex_rd_addr, ex_reg_write, ex_is_load, ex_ctrl_taken,
    output mem_rd_addr, mem_reg_write, wb_rd_addr, wb_reg_write,
    input  stall_if, stall_de, flush_de, flush_ex,
    input  fwd_a_sel, fwd_b_sel, stall_count, flush_count
  );

  modport slave (
    input  de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
    input  ex_rd_addr, ex_reg_write, ex_is_load, ex_ctrl_taken,
    input  mem_rd_addr, mem_reg_write, wb_rd_addr, wb_reg_write,
    output stall_if, stall_de, flush_de, flush_ex,
    output fwd_a_sel, fwd_b_sel, stall_count, flush_count
  );

endinterface

// File: rtl/otter_fwd_unit.sv
// Per-operand forward select: newest live producer (MEM before WB) wins.
module otter_fwd_unit
  import otter_pkg::*;
(
  input  reg_addr_t i_rs_addr,
  input  logic      i_rs_used,
  input  wr_port_t  i_mem,
  input  wr_port_t  i_wb,
  output fwd_sel_t  o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_rs_used) begin
      if (wr_hits(i_mem, i_rs_addr)) begin
        o_sel = FWD_MEM;
      end else if (wr_hits(i_wb, i_rs_addr)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// Stall / flush / forwarding controller for the 5-stage OTTER pipeline,
// with saturating stall and flush event counters.
module otter_hazard_ctrl
  import otter_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input logic              CLK,
  input logic              RST,
  otter_hazard_ctrl_if.slave hz
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_MAX    = '1;

  hz_state_t              r_state;
  hz_state_t              w_state_nxt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic [FLUSH_CNT_W-1:0] w_flush_cnt_nxt;
  logic [CNT_W-1:0]       r_stall_count;
  logic [CNT_W-1:0]       r_flush_count;

  logic     w_load_use;
  logic     w_stall;
  logic     w_flush;
  logic     w_flush_evt;
  wr_port_t w_mem_wr;
  wr_port_t w_wb_wr;
  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;

  assign w_mem_wr = '{rd: hz.mem_rd_addr, reg_write: hz.mem_reg_write};
  assign w_wb_wr  = '{rd: hz.wb_rd_addr,  reg_write: hz.wb_reg_write};

  otter_fwd_unit u_fwd_a (
    .i_rs_addr (hz.de_rs1_addr),
    .i_rs_used (hz.de_rs1_used),
    .i_mem     (w_mem_wr),
    .i_wb      (w_wb_wr),
    .o_sel     (w_fwd_a)
  );

  otter_fwd_unit u_fwd_b (
    .i_rs_addr (hz.de_rs2_addr),
    .i_rs_used (hz.de_rs2_used),
    .i_mem     (w_mem_wr),
    .i_wb      (w_wb_wr),
    .o_sel     (w_fwd_b)
  );

  // A load in EX whose result a used DE source needs cannot be forwarded in time.
  always_comb begin
    w_load_use = 1'b0;
    if (hz.ex_is_load && hz.ex_reg_write && (hz.ex_rd_addr != '0)) begin
      w_load_use = (hz.de_rs1_used && (hz.de_rs1_addr == hz.ex_rd_addr)) ||
                   (hz.de_rs2_used && (hz.de_rs2_addr == hz.ex_rd_addr));
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // The first squash cycle happens in RUN, so FLUSH covers the remaining FLUSH_CYCLES-1.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_stall         = 1'b0;
    w_flush         = 1'b0;
    w_flush_evt     = 1'b0;
    case (r_state)
      RUN: begin
        if (hz.ex_ctrl_taken) begin
          w_flush     = 1'b1;
          w_flush_evt = 1'b1;
          if (FLUSH_LOAD != '0) begin
            w_state_nxt     = FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
          end
        end else if (w_load_use) begin
          w_stall     = 1'b1;
          w_state_nxt = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        w_state_nxt = RUN;
      end
      FLUSH: begin
        w_flush         = 1'b1;
        w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
        if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
          w_state_nxt     = RUN;
          w_flush_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  // Combinational controls are forced quiet while reset is held.
  assign hz.stall_if    = w_stall & ~RST;
  assign hz.stall_de    = w_stall & ~RST;
  assign hz.flush_de    = w_flush & ~RST;
  assign hz.flush_ex    = (w_flush | w_stall) & ~RST;
  assign hz.fwd_a_sel   = RST ? FWD_RF : w_fwd_a;
  assign hz.fwd_b_sel   = RST ? FWD_RF : w_fwd_b;
  assign hz.stall_count = r_stall_count;
  assign hz.flush_count = r_flush_count;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl: vector table plus reset/flush/saturation sequences.
module tb_otter_hazard_ctrl;
  import otter_pkg::*;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exrd;
    logic       exw, exld, tk;
    logic [4:0] memrd;
    logic       memw;
    logic [4:0] wbrd;
    logic       wbw;
    logic [3:0] ctl;  // {stall_if, stall_de, flush_de, flush_ex}
    logic [1:0] fa, fb;
  } vec_t;

  localparam int N = 21;

  logic CLK;
  logic RST;
  int   total;
  int   bad;
  vec_t v [N];
  vec_t idle;

  otter_hazard_ctrl_if #(.CNT_W(32)) hz0 ();
  otter_hazard_ctrl_if #(.CNT_W(2))  hz1 ();

  otter_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_dut0 (.CLK(CLK), .RST(RST), .hz(hz0));
  otter_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2))  u_dut1 (.CLK(CLK), .RST(RST), .hz(hz1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2,
                              input logic [4:0] exrd, input logic exw, input logic exld,
                              input logic tk, input logic [4:0] memrd, input logic memw,
                              input logic [4:0] wbrd, input logic wbw,
                              input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
    vec_t r;
    r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
    r.exrd = exrd; r.exw = exw; r.exld = exld; r.tk = tk;
    r.memrd = memrd; r.memw = memw; r.wbrd = wbrd; r.wbw = wbw;
    r.ctl = ctl; r.fa = fa; r.fb = fb;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    hz0.de_rs1_addr = x.rs1;   hz1.de_rs1_addr = x.rs1;
    hz0.de_rs2_addr = x.rs2;   hz1.de_rs2_addr = x.rs2;
    hz0.de_rs1_used = x.u1;    hz1.de_rs1_used = x.u1;
    hz0.de_rs2_used = x.u2;    hz1.de_rs2_used = x.u2;
    hz0.ex_rd_addr = x.exrd;   hz1.ex_rd_addr = x.exrd;
    hz0.ex_reg_write = x.exw;  hz1.ex_reg_write = x.exw;
    hz0.ex_is_load = x.exld;   hz1.ex_is_load = x.exld;
    hz0.ex_ctrl_taken = x.tk;  hz1.ex_ctrl_taken = x.tk;
    hz0.mem_rd_addr = x.memrd; hz1.mem_rd_addr = x.memrd;
    hz0.mem_reg_write = x.memw; hz1.mem_reg_write = x.memw;
    hz0.wb_rd_addr = x.wbrd;   hz1.wb_rd_addr = x.wbrd;
    hz0.wb_reg_write = x.wbw;  hz1.wb_reg_write = x.wbw;
  endtask

  // Inputs change on the rising edge; state moves on the falling edge.
  task automatic step(input vec_t x);
    @(posedge CLK);
    drive(x);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t x);
    chk({nm, "_stall_if"}, 32'(hz0.stall_if), 32'(x.ctl[3]));
    chk({nm, "_stall_de"}, 32'(hz0.stall_de), 32'(x.ctl[2]));
    chk({nm, "_flush_de"}, 32'(hz0.flush_de), 32'(x.ctl[1]));
    chk({nm, "_flush_ex"}, 32'(hz0.flush_ex), 32'(x.ctl[0]));
    chk({nm, "_fwd_a"},    32'(hz0.fwd_a_sel), 32'(x.fa));
    chk({nm, "_fwd_b"},    32'(hz0.fwd_b_sel), 32'(x.fb));
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    RST = 1'b1;
    drive(idle);
    @(posedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle  = mk(0,0,0,0, 0,0,0,0, 0,0, 0,0, 4'b0000, 2'd0, 2'd0);

    //          rs1 rs2 u1 u2  exrd w ld tk  mem w  wb w   ctl      fa fb
    v[0]  = mk(0,  0,  0, 0,  0,  0, 0, 0,  0, 0,  0, 0,  4'b0000, 0, 0);
    v[1]  = mk(5,  0,  1, 0,  5,  1, 0, 0,  5, 1,  0, 0,  4'b0000, 1, 0);
    v[2]  = mk(0,  7,  0, 1,  0,  0, 0, 0,  7, 1,  7, 1,  4'b0000, 0, 1);
    v[3]  = mk(0,  7,  0, 1,  0,  0, 0, 0,  0, 0,  7, 1,  4'b0000, 0, 2);
    v[4]  = mk(0,  7,  0, 1,  0,  0, 0, 0,  7, 0,  7, 1,  4'b0000, 0, 2);
    v[5]  = mk(9,  0,  0, 0,  0,  0, 0, 0,  9, 1,  9, 1,  4'b0000, 0, 0);
    v[6]  = mk(0,  0,  1, 1,  0,  1, 1, 0,  0, 1,  0, 1,  4'b0000, 0, 0);
    v[7]  = mk(4,  6,  1, 1,  0,  0, 0, 0,  4, 1,  6, 1,  4'b0000, 1, 2);
    v[8]  = mk(3,  0,  1, 0,  3,  1, 0, 0,  0, 0,  0, 0,  4'b0000, 0, 0);
    v[9]  = mk(3,  0,  1, 0,  3,  1, 1, 0,  0, 0,  0, 0,  4'b1101, 0, 0);
    v[10] = mk(3,  0,  1, 0,  3,  1, 1, 0,  3, 1,  0, 0,  4'b0000, 1, 0);
    v[11] = mk(3,  0,  1, 0,  0,  0, 0, 0,  0, 0,  3, 1,  4'b0000, 2, 0);
    v[12] = mk(1,  8,  0, 1,  8,  1, 1, 0,  0, 0,  0, 0,  4'b1101, 0, 0);
    v[13] = mk(0,  0,  0, 0,  0,  0, 0, 0,  8, 1,  0, 0,  4'b0000, 0, 0);
    v[14] = mk(0,  8,  0, 0,  8,  1, 1, 0,  0, 0,  0, 0,  4'b0000, 0, 0);
    v[15] = mk(0,  0,  0, 0,  0,  0, 0, 1,  0, 0,  0, 0,  4'b0011, 0, 0);
    v[16] = mk(2,  0,  1, 0,  2,  1, 1, 0,  2, 1,  0, 0,  4'b0011, 1, 0);
    v[17] = mk(0,  0,  0, 0,  0,  0, 0, 0,  0, 0,  0, 0,  4'b0000, 0, 0);
    v[18] = mk(3,  0,  1, 0,  3,  1, 1, 1,  0, 0,  0, 0,  4'b0011, 0, 0);
    v[19] = mk(0,  0,  0, 0,  0,  0, 0, 0,  0, 0,  0, 0,  4'b0011, 0, 0);
    v[20] = mk(0,  0,  0, 0,  0,  0, 0, 0,  0, 0,  0, 0,  4'b0000, 0, 0);

    // Reset held with hazard-provoking inputs: everything must read zero.
    RST = 1'b1;
    drive(mk(4,6,1,1, 4,1,1,1, 4,1, 6,1, 4'b0000, 0, 0));
    #12;
    chk("rst_vec", 32'({hz0.stall_if, hz0.stall_de, hz0.flush_de, hz0.flush_ex}), 32'h0);
    chk("rst_fwd", 32'({hz0.fwd_a_sel, hz0.fwd_b_sel}), 32'h0);
    chk("rst_stall_count", hz0.stall_count, 32'd0);
    chk("rst_flush_count", hz0.flush_count, 32'd0);
    @(posedge CLK);
    drive(idle);
    RST = 1'b0;

    for (int i = 0; i < N; i++) begin
      step(v[i]);
      chk_vec($sformatf("vec%0d", i), v[i]);
    end
    @(negedge CLK); #1;
    chk("table_stall_count", hz0.stall_count, 32'd2);
    chk("table_flush_count", hz0.flush_count, 32'd2);

    // Single load-use then taken+load-use from a clean reset.
    pulse_reset();
    step(v[9]);  chk("seqA_stall", 32'(hz0.stall_if), 32'd1);
    step(v[11]); chk("seqA_fwd_wb", 32'(hz0.fwd_a_sel), 32'd2);
    chk("seqA_stall_count", hz0.stall_count, 32'd1);
    step(v[18]); chk("seqA_both_stall_if", 32'(hz0.stall_if), 32'd0);
    chk("seqA_both_flush", 32'({hz0.flush_de, hz0.flush_ex}), 32'h3);
    step(v[19]); step(idle);
    chk("seqA_after_flush", 32'({hz0.flush_de, hz0.flush_ex}), 32'h0);
    chk("seqA_stall_count2", hz0.stall_count, 32'd1);
    chk("seqA_flush_count", hz0.flush_count, 32'd1);

    // Reset in the middle of a flush window.
    step(v[15]);
    @(posedge CLK);
    drive(v[16]);
    RST = 1'b1;
    #1;
    chk("seqB_rst_ctl", 32'({hz0.stall_if, hz0.stall_de, hz0.flush_de, hz0.flush_ex}), 32'h0);
    chk("seqB_rst_fwd", 32'(hz0.fwd_a_sel), 32'd0);
    chk("seqB_rst_flush_count", hz0.flush_count, 32'd0);
    @(posedge CLK);
    drive(idle);
    RST = 1'b0;
    #1;
    chk("seqB_release_flush", 32'({hz0.flush_de, hz0.flush_ex}), 32'h0);
    chk("seqB_release_dut1", 32'({hz1.flush_de, hz1.flush_ex}), 32'h0);

    // Saturation (2-bit counters on dut1) and a 3-cycle flush window.
    for (int k = 0; k < 4; k++) begin
      step(v[9]);
      step(idle);
    end
    chk("seqC_stall_count32", hz0.stall_count, 32'd4);
    chk("seqC_stall_count_sat", 32'(hz1.stall_count), 32'd3);
    for (int k = 0; k < 4; k++) begin
      step(v[15]);
      chk($sformatf("seqC%0d_c1", k), 32'({hz0.flush_de, hz1.flush_de}), 32'h3);
      step(idle);
      chk($sformatf("seqC%0d_c2", k), 32'({hz0.flush_de, hz1.flush_de}), 32'h3);
      step(idle);
      chk($sformatf("seqC%0d_c3", k), 32'({hz0.flush_de, hz1.flush_de}), 32'h1);
      step(idle);
      chk($sformatf("seqC%0d_c4", k), 32'({hz0.flush_de, hz1.flush_de}), 32'h0);
    end
    @(negedge CLK); #1;
    chk("seqC_flush_count32", hz0.flush_count, 32'd4);
    chk("seqC_flush_count_sat", 32'(hz1.flush_count), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
